// File: rtl/memory.sv
// memory: word-addressed RAM, 2^(ADDR_W-2) words, async clear on rst_n low.
// Define MEMORY_ALIGN_CHECK_EN to add align_err and block misaligned access.
module memory #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writeData,
   input  logic              trigWrite,
   input  logic              trigRead,
   output logic [DATA_W-1:0] readData
`ifdef MEMORY_ALIGN_CHECK_EN
   ,
   output logic              align_err
`endif
);

   localparam int WORDS = 1 << (ADDR_W - 2);

   logic [DATA_W-1:0] mem [WORDS];
   logic [ADDR_W-3:0] idx;
   logic              wr_ok;
   logic              rd_ok;

   assign idx = address[ADDR_W-1:2];

`ifdef MEMORY_ALIGN_CHECK_EN
   logic misal;

   assign misal     = (address[1:0] != 2'b00);
   assign align_err = (trigRead | trigWrite) & misal;
   assign wr_ok     = trigWrite & ~misal;
   assign rd_ok     = trigRead & ~misal;
`else
   // Low address bits alias within a word.
   logic unused_lo;

   assign unused_lo = ^address[1:0];
   assign wr_ok     = trigWrite;
   assign rd_ok     = trigRead;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[idx] <= writeData;
      end
   end

   assign readData = rd_ok ? mem[idx] : '0;

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed plus randomized checks of memory against a word-array
// model; builds with or without MEMORY_ALIGN_CHECK_EN.
module tb_memory;

`ifdef MEMORY_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [6:0]  address;
   logic [31:0] writeData;
   logic        trigWrite;
   logic        trigRead;
   logic [31:0] readData;
`ifdef MEMORY_ALIGN_CHECK_EN
   logic        align_err;
`endif

   logic [31:0] ref_mem [32];
   int          tests;
   int          fails;

   memory #(.DATA_W(32), .ADDR_W(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .address   (address),
      .writeData (writeData),
      .trigWrite (trigWrite),
      .trigRead  (trigRead),
      .readData  (readData)
`ifdef MEMORY_ALIGN_CHECK_EN
      ,
      .align_err (align_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [6:0] a,
                                            input logic rd);
      if (!rd) return 32'h0;
      if (ALIGN && a[1:0] != 2'b00) return 32'h0;
      return ref_mem[a[6:2]];
   endfunction

   task automatic model_wr(input logic [6:0] a, input logic [31:0] d);
      if (!(ALIGN && a[1:0] != 2'b00)) ref_mem[a[6:2]] = d;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
   endtask

   task automatic chk_err(input string tag, input logic [6:0] a);
`ifdef MEMORY_ALIGN_CHECK_EN
      chk(tag, {31'h0, align_err},
          {31'h0, (trigRead | trigWrite) && a[1:0] != 2'b00});
`endif
   endtask

   task automatic do_write(input logic [6:0] a, input logic [31:0] d);
      @(negedge clk);
      address   = a;
      writeData = d;
      trigWrite = 1'b1;
      trigRead  = 1'b0;
      @(posedge clk);
      #1;
      trigWrite = 1'b0;
      model_wr(a, d);
   endtask

   task automatic do_read(input string tag, input logic [6:0] a);
      @(negedge clk);
      address  = a;
      trigRead = 1'b1;
      #1;
      chk(tag, readData, model_rd(a, 1'b1));
      trigRead = 1'b0;
   endtask

   initial begin
      logic [6:0]  ra;
      logic [31:0] rd_d;
      logic        rw;
      logic        rr;

      tests     = 0;
      fails     = 0;
      rst_n     = 1'b1;
      address   = '0;
      writeData = '0;
      trigWrite = 1'b0;
      trigRead  = 1'b0;
      model_clear();

      #2 rst_n = 1'b0;
      #1;
      chk("reset_out", readData, 32'h0);
`ifdef MEMORY_ALIGN_CHECK_EN
      chk("reset_err", {31'h0, align_err}, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) begin
         do_read("reset_word", 7'(i * 4));
      end

      do_write(7'd8, 32'hDEADBEEF);
      address  = 7'd8;
      trigRead = 1'b1;
      #1;
      chk("wr_then_rd", readData, 32'hDEADBEEF);
      trigRead = 1'b0;
      do_read("neighbor_12", 7'd12);

      do_write(7'd16, 32'h11111111);
      @(negedge clk);
      address   = 7'd16;
      writeData = 32'h22222222;
      trigRead  = 1'b1;
      trigWrite = 1'b1;
      #1;
      chk("rw_old", readData, 32'h11111111);
      @(posedge clk);
      #1;
      trigWrite = 1'b0;
      model_wr(7'd16, 32'h22222222);
      chk("rw_new", readData, 32'h22222222);
      trigRead = 1'b0;

      do_write(7'd4, 32'h12345678);
      @(negedge clk);
      address  = 7'd4;
      trigRead = 1'b1;
      #1;
      chk("pre_rst", readData, 32'h12345678);
      #1 rst_n = 1'b0;
      #1;
      model_clear();
      chk("async_clr", readData, 32'h0);
      writeData = 32'hCAFEF00D;
      trigWrite = 1'b1;
      @(posedge clk);
      #1;
      chk("wr_in_rst", readData, 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      trigWrite = 1'b0;
      trigRead  = 1'b0;
      do_read("post_rst_16", 7'd16);
      do_write(7'd4, 32'h0BADCAFE);
      do_read("first_wr", 7'd4);

      do_write(7'd0, 32'hFFFFFFFF);
      @(negedge clk);
      address  = 7'd0;
      trigRead = 1'b0;
      #1;
      chk("rd_off", readData, 32'h0);
      do_write(7'd124, 32'h7E7E0124);
      do_read("last_word", 7'd124);
      do_read("word0_kept", 7'd0);

      @(negedge clk);
      address   = 7'd5;
      writeData = 32'hA5A5A5A5;
      trigWrite = 1'b1;
      #1;
      chk_err("misal_err", 7'd5);
      @(posedge clk);
      #1;
      trigWrite = 1'b0;
      model_wr(7'd5, 32'hA5A5A5A5);
      do_read("alias_4", 7'd4);
      do_read("alias_7", 7'd7);

      for (int n = 0; n < 300; n++) begin
         ra   = 7'($urandom_range(0, 127));
         rd_d = $urandom;
         rw   = 1'($urandom_range(0, 1));
         rr   = 1'($urandom_range(0, 1));
         @(negedge clk);
         address   = ra;
         writeData = rd_d;
         trigWrite = rw;
         trigRead  = rr;
         #1;
         chk("rnd_pre", readData, model_rd(ra, rr));
         chk_err("rnd_err", ra);
         if ($urandom_range(0, 39) == 0) begin
            #1 rst_n = 1'b0;
            #1;
            model_clear();
            chk("rnd_rst", readData, 32'h0);
            @(posedge clk);
            #1;
            chk("rnd_rst_wr", readData, 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            if (rw) model_wr(ra, rd_d);
            chk("rnd_post", readData, model_rd(ra, rr));
         end
         trigWrite = 1'b0;
         trigRead  = 1'b0;
      end

      for (int i = 0; i < 32; i++) begin
         do_read("final_sweep", 7'(i * 4));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
